// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the 7-segment BCD display scanner.
// Segment patterns are active-low, bit order g,f,e,d,c,b,a (bit6..bit0).
// Digit-slot index encoding shared by the scanner and any future users.
package bcd_disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_MINUS = 7'b0111111;

    // Digit slot index: scanned ones -> tens -> huns -> sign -> ones.
    typedef enum logic [1:0] {
        IDX_ONES = 2'd0,
        IDX_TENS = 2'd1,
        IDX_HUNS = 2'd2,
        IDX_SIGN = 2'd3
    } idx_t;

    // Displayed value: three BCD nibbles plus sign.
    typedef struct packed {
        logic [3:0] huns;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       neg;
    } disp_val_t;

    // Successor slot in scan order.
    function automatic idx_t idx_next(input idx_t cur);
        idx_t nxt;
        case (cur)
            IDX_ONES: nxt = IDX_TENS;
            IDX_TENS: nxt = IDX_HUNS;
            IDX_HUNS: nxt = IDX_SIGN;
            default:  nxt = IDX_ONES;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Purpose: BCD nibble to active-low 7-segment pattern, with blank override.
// Latency: purely combinational.
// Backpressure: none; nibbles above 9 render as 'E'.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output seg_t       seg_n_o
);

    // Decode nibble, blank flag wins over any digit.
    always_comb begin
        seg_n_o = SEG_E;
        if (blank_i) begin
            seg_n_o = SEG_BLANK;
        end else begin
            case (nib_i)
                4'd0:    seg_n_o = SEG_0;
                4'd1:    seg_n_o = SEG_1;
                4'd2:    seg_n_o = SEG_2;
                4'd3:    seg_n_o = SEG_3;
                4'd4:    seg_n_o = SEG_4;
                4'd5:    seg_n_o = SEG_5;
                4'd6:    seg_n_o = SEG_6;
                4'd7:    seg_n_o = SEG_7;
                4'd8:    seg_n_o = SEG_8;
                4'd9:    seg_n_o = SEG_9;
                default: seg_n_o = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Purpose: time-multiplexed 4-slot 7-segment scanner with double-buffered value.
// Latency: outputs registered, one clock behind (index, prescaler) state.
// Backpressure: none; load is a strobe, value swaps in only at frame boundaries.
module bcd_seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_ones,
    input  logic [3:0] in_tens,
    input  logic [3:0] in_huns,
    input  logic       in_neg,
    input  logic       load,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       frame
);

    localparam int             PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]  BLANK_LIM  = PW'(BLANK_CYC);

    logic [PW-1:0] presc_q, presc_d;
    idx_t          idx_q, idx_d;
    disp_val_t     pend_q, pend_d;
    disp_val_t     act_q, act_d;
    logic [3:0]    an_q, an_d;
    seg_t          seg_q, seg_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          boundary;
    disp_val_t     in_val;
    logic [3:0]    nib;
    logic          nib_blank;
    seg_t          digit_seg;
    seg_t          sign_seg;

    // Prescaler/index advance and frame-boundary detection.
    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        boundary = tick && (idx_q == IDX_SIGN);
        presc_d  = tick ? '0 : presc_q + PW'(1);
        idx_d    = tick ? idx_next(idx_q) : idx_q;
    end

    // Double buffer: load fills pending; active swaps at the boundary,
    // taking the incoming value directly if load lands on that same cycle.
    always_comb begin
        in_val = {in_huns, in_tens, in_ones, in_neg};
        pend_d = load ? in_val : pend_q;
        act_d  = act_q;
        if (boundary) begin
            act_d = load ? in_val : pend_q;
        end
    end

    // Pick the nibble for the current slot and apply leading-zero blanking.
    always_comb begin
        nib       = act_q.ones;
        nib_blank = 1'b0;
        case (idx_q)
            IDX_ONES: begin
                nib       = act_q.ones;
                nib_blank = 1'b0;
            end
            IDX_TENS: begin
                nib       = act_q.tens;
                nib_blank = (act_q.huns == 4'd0) && (act_q.tens == 4'd0);
            end
            IDX_HUNS: begin
                nib       = act_q.huns;
                nib_blank = (act_q.huns == 4'd0);
            end
            default: begin
                nib       = 4'd0;
                nib_blank = 1'b1;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .nib_i   (nib),
        .blank_i (nib_blank),
        .seg_n_o (digit_seg)
    );

    // Output next-state: minus only for a nonzero negative magnitude,
    // anodes dark for the first BLANK_CYC clocks of every slot.
    always_comb begin
        sign_seg = SEG_BLANK;
        if (act_q.neg && ({act_q.huns, act_q.tens, act_q.ones} != 12'd0)) begin
            sign_seg = SEG_MINUS;
        end
        seg_d = (idx_q == IDX_SIGN) ? sign_seg : digit_seg;
        an_d  = 4'b1111;
        if (presc_q >= BLANK_LIM) begin
            case (idx_q)
                IDX_ONES: an_d = 4'b1110;
                IDX_TENS: an_d = 4'b1101;
                IDX_HUNS: an_d = 4'b1011;
                default:  an_d = 4'b0111;
            endcase
        end
        frame_d = boundary;
    end

    // State and output registers; reset darkens the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= IDX_ONES;
            pend_q  <= '0;
            act_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign an_n  = an_q;
    assign seg_n = seg_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
module tb_bcd_seg_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_ones, in_tens, in_huns;
    logic       in_neg;
    logic       load;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       frame;

    always #5 clk = ~clk;

    bcd_seg_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_ones (in_ones),
        .in_tens (in_tens),
        .in_huns (in_huns),
        .in_neg  (in_neg),
        .load    (load),
        .an_n    (an_n),
        .seg_n   (seg_n),
        .frame   (frame)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed clocks since reset release plus the two
    // buffered values, packed {huns, tens, ones, neg}.
    int          n_clk;
    logic [12:0] pend_m;
    logic [12:0] act_m;

    function automatic logic [6:0] digit_pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0000110;
        endcase
    endfunction

    // What a given slot of a value looks like on the display.
    function automatic logic [6:0] slot_pat(input logic [12:0] v, input int slot);
        logic [3:0] h, t, o;
        logic       ng;
        h  = v[12:9];
        t  = v[8:5];
        o  = v[4:1];
        ng = v[0];
        case (slot)
            0: return digit_pat(o);
            1: return (h == 0 && t == 0) ? 7'b1111111 : digit_pat(t);
            2: return (h == 0) ? 7'b1111111 : digit_pat(h);
            default: return (ng && (h != 0 || t != 0 || o != 0)) ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict registered outputs from the state
    // before the edge, advance model, sample 1ns after the edge.
    task automatic step(input logic ld, input logic [12:0] v);
        int         presc, slot;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_fr;
        load = ld;
        {in_huns, in_tens, in_ones, in_neg} = v;
        presc = n_clk % 4;
        slot  = (n_clk / 4) % 4;
        e_an  = (presc < 1) ? 4'b1111 : ~(4'b0001 << slot);
        e_seg = slot_pat(act_m, slot);
        e_fr  = (presc == 3) && (slot == 3);
        if (e_fr) act_m = ld ? v : pend_m;
        if (ld) pend_m = v;
        n_clk++;
        @(posedge clk);
        #1;
        check("an_n", an_n, e_an);
        check("seg_n", seg_n, e_seg);
        check("frame", frame, e_fr);
        load = 1'b0;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 13'd0);
    endtask

    function automatic logic [12:0] val(input int h, input int t, input int o, input bit ng);
        logic [12:0] r;
        r = {h[3:0], t[3:0], o[3:0], ng};
        return r;
    endfunction

    function automatic logic [3:0] rnd_nib();
        logic [3:0] r;
        r = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return r;
    endfunction

    initial begin
        int fc;
        logic [12:0] rv;
        rst_n = 1'b1;
        load  = 1'b0;
        {in_huns, in_tens, in_ones, in_neg} = 13'd0;

        // Reset asserted away from any edge: outputs go dark immediately.
        #2 rst_n = 1'b0;
        #1;
        check("rst_an", an_n, 4'b1111);
        check("rst_seg", seg_n, 7'b1111111);
        check("rst_frame", frame, 1'b0);

        // Loads under reset are ignored; outputs stay reset across edges.
        load = 1'b1;
        {in_huns, in_tens, in_ones, in_neg} = val(9, 9, 9, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_an", an_n, 4'b1111);
        check("rst_hold_seg", seg_n, 7'b1111111);
        load = 1'b0;
        rst_n = 1'b1;
        n_clk = 0;
        pend_m = 13'd0;
        act_m = 13'd0;

        // Two frames with no load: display stays 000 through a boundary.
        idle(32);

        // 123 positive, shown one frame later; count frame pulses.
        step(1'b1, val(1, 2, 3, 0));
        fc = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 13'd0);
            if (frame === 1'b1) fc++;
        end
        check("frame_rate", fc, 4);

        // -007: huns/tens blank, minus shown.
        step(1'b1, val(0, 0, 7, 1));
        idle(40);
        // -000: no minus.
        step(1'b1, val(0, 0, 0, 1));
        idle(40);
        // Invalid tens nibble shows E.
        step(1'b1, val(0, 12, 5, 0));
        idle(40);

        // Load at index 1 is held until the 3->0 boundary.
        while ((n_clk % 16) != 5) step(1'b0, 13'd0);
        step(1'b1, val(4, 5, 6, 0));
        idle(30);
        // Load exactly on the boundary cycle bypasses pending.
        while ((n_clk % 16) != 15) step(1'b0, 13'd0);
        step(1'b1, val(8, 0, 9, 1));
        idle(20);
        // Boundary load followed by a mid-frame load.
        while ((n_clk % 16) != 15) step(1'b0, 13'd0);
        step(1'b1, val(3, 3, 1, 0));
        step(1'b1, val(2, 7, 0, 1));
        idle(40);

        // Randomized loads.
        for (int i = 0; i < 600; i++) begin
            rv = {rnd_nib(), rnd_nib(), rnd_nib(), 1'($urandom_range(0, 1))};
            step($urandom_range(0, 5) == 0, rv);
        end

        // Mid-slot reset with a visible value.
        step(1'b1, val(5, 5, 5, 1));
        idle(20);
        while ((n_clk % 4) != 2) step(1'b0, 13'd0);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_an", an_n, 4'b1111);
        check("midrst_seg", seg_n, 7'b1111111);
        check("midrst_frame", frame, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_clk = 0;
        pend_m = 13'd0;
        act_m = 13'd0;
        idle(36);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clocks per digit slot (>=2).
REQ-002 SHALL have parameter BLANK_CYC, default 500: blanked clocks at the start of each slot (< SCAN_DIV).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_ones  in  4  BCD ones digit from bcd_sub.
REQ-006 SHALL have port in_tens  in  4  BCD tens digit from bcd_sub.
REQ-007 SHALL have port in_huns  in  4  BCD hundreds digit from bcd_sub.
REQ-008 SHALL have port in_neg  in  1  sign flag from bcd_sub.
REQ-009 SHALL have port load  in  1  single-cycle strobe capturing in_* into the pending register.
REQ-010 SHALL have port an_n  out  4  active-low digit enables; bit0=ones, bit1=tens, bit2=huns, bit3=sign.
REQ-011 SHALL have port seg_n  out  7  active-low segments; bit order g,f,e,d,c,b,a (bit6..bit0).
REQ-012 SHALL have port frame  out  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; terminal count is a slot tick.
REQ-014 On each slot tick, digit index SHALL advance 0->1->2->3->0.
REQ-015 Frame boundary SHALL be the tick where index goes 3->0; frame SHALL pulse for exactly that cycle.
REQ-016 load SHALL write pending {huns,tens,ones,neg} on the same edge; load is ignored when rst_n=0.
REQ-017 At the frame boundary, active SHALL take pending; mid-frame loads SHALL NOT alter the active register.
REQ-018 If load coincides with the frame boundary, active SHALL take the newly loaded in_* values directly (bypass).
REQ-019 Segment patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 A nibble >9 SHALL display E=0000110.
REQ-021 Hundreds SHALL be blank (1111111) when huns=0; tens SHALL be blank when huns=0 and tens=0; ones SHALL never blank.
REQ-022 Sign slot SHALL show minus (0111111) iff neg=1 and the magnitude is not 000; otherwise it SHALL be blank.
REQ-023 While prescaler < BLANK_CYC, an_n SHALL be 1111; otherwise an_n SHALL be the active-low one-hot of the index.
REQ-024 an_n, seg_n and frame SHALL be registered and lag the (index, prescaler) state by exactly one clock.

Reset
REQ-025 rst_n=0 SHALL immediately force an_n=1111, seg_n=1111111 and frame=0.
REQ-026 rst_n=0 SHALL clear prescaler, index, pending and active to zero.
REQ-027 After release, scanning SHALL restart at index 0 with prescaler 0; the value shown SHALL be 000 until the first frame boundary following a load.

Structure
REQ-028 Shared package bcd_disp_pkg SHALL hold the segment pattern constants (digits, E, blank, minus) and the 2-bit digit index encodings.
REQ-029 The design SHALL contain one combinational sub-module, bcd_to_seg (nibble + blank flag -> seg_n).
REQ-030 Prescaler, index, double buffer and output registers SHALL live in bcd_seg_scan.

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-031 Load 1,2,3 with neg=0, then wait one frame -> slots show:
- an_n 1110 with seg_n 0110000
- an_n 1101 with seg_n 0100100
- an_n 1011 with seg_n 1111001
- an_n 0111 with seg_n 1111111
- an_n=1111 during the first cycle of each slot.
REQ-032 Load 007 with neg=1 -> hundreds and tens blank, ones 1111000, sign 0111111.
REQ-033 Load 000 with neg=1 -> ones 1000000, sign blank; tens=4'hC -> tens slot 0000110.
REQ-034 Load at index 1 -> display unchanged until the 3->0 boundary; load on the boundary cycle -> new value appears in slot 0 of the next frame; frame pulses once per 16 clocks.
REQ-035 Drop rst_n mid-slot -> an_n=1111 and seg_n=1111111 without waiting for a clock edge; after release, index 0 resumes after a one-clock output lag.
